// File: rtl/qam_demod_correlator.sv
// rtl/qam_demod_correlator.sv - 16-QAM correlating demodulator: mix with LUT carrier, integrate per symbol, slice
module qam_demod_correlator #(
    parameter int                      SAMPLES_PER_SYMBOL = 1024,
    parameter int                      ACC_W              = 42,
    parameter logic signed [ACC_W-1:0] THRESH             = 42'sd268435456
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sym_start,
    input  logic signed [15:0]      rx_sample,
    input  logic signed [15:0]      sampled_sine,
    input  logic signed [15:0]      sampled_cosine,
    output logic [3:0]              symbol,
    output logic                    symbol_valid,
    output logic signed [ACC_W-1:0] i_acc_out,
    output logic signed [ACC_W-1:0] q_acc_out,
    output logic                    busy
);
    localparam int CNT_W = $clog2(SAMPLES_PER_SYMBOL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_SYMBOL - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      s1_valid_q, s1_first_q, s1_last_q;
    logic signed [31:0]        pi_q, pq_q;
    logic                      s2_last_q;
    logic signed [ACC_W-1:0]   acc_i_q, acc_q_q;

    logic                      accept_d;
    logic [CNT_W-1:0]          cur_cnt_d;
    logic [CNT_W-1:0]          cnt_d;
    logic signed [31:0]        pi_d, pq_d;
    logic signed [ACC_W-1:0]   pi_ext_d, pq_ext_d;

    function automatic logic [1:0] slice(input logic signed [ACC_W-1:0] v);
        if (v >= THRESH)
            return 2'b10;
        else if (!v[ACC_W-1])
            return 2'b11;
        else if (v >= -THRESH)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // A sym_start sample always becomes sample 0: covers both IDLE entry and mid-symbol resync.
    always_comb begin
        accept_d  = en && ((state_q == RUN) || sym_start);
        cur_cnt_d = sym_start ? '0 : cnt_q;
        cnt_d     = (cur_cnt_d == LAST_CNT) ? '0 : cur_cnt_d + 1'b1;
        pi_d      = 32'(rx_sample) * 32'(sampled_cosine);
        pq_d      = 32'(rx_sample) * 32'(sampled_sine);
        pi_ext_d  = {{(ACC_W-32){pi_q[31]}}, pi_q};
        pq_ext_d  = {{(ACC_W-32){pq_q[31]}}, pq_q};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            pi_q         <= '0;
            pq_q         <= '0;
            s2_last_q    <= 1'b0;
            acc_i_q      <= '0;
            acc_q_q      <= '0;
            symbol       <= '0;
            symbol_valid <= 1'b0;
            i_acc_out    <= '0;
            q_acc_out    <= '0;
        end else begin
            s1_valid_q <= accept_d;
            if (accept_d) begin
                state_q    <= RUN;
                cnt_q      <= cnt_d;
                s1_first_q <= (cur_cnt_d == '0);
                s1_last_q  <= (cur_cnt_d == LAST_CNT);
                pi_q       <= pi_d;
                pq_q       <= pq_d;
            end

            s2_last_q <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                acc_i_q <= s1_first_q ? pi_ext_d : acc_i_q + pi_ext_d;
                acc_q_q <= s1_first_q ? pq_ext_d : acc_q_q + pq_ext_d;
            end

            // Stage 3 reads the completed integrals before a same-edge first sample overwrites them.
            symbol_valid <= s2_last_q;
            if (s2_last_q) begin
                i_acc_out <= acc_i_q;
                q_acc_out <= acc_q_q;
                symbol    <= {slice(acc_i_q), slice(acc_q_q)};
            end
        end
    end

    assign busy = (state_q == RUN);
endmodule

// File: tb/tb_qam_demod_correlator.sv
// tb/tb_qam_demod_correlator.sv - directed-vector bench for qam_demod_correlator
module tb_qam_demod_correlator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, en_s, en_l, ss;
    logic signed [15:0] rx, sn, cs;

    logic [3:0]         sym_s, sym_l;
    logic               val_s, val_l, busy_s, busy_l;
    logic signed [41:0] i_s, q_s, i_l, q_l;

    qam_demod_correlator #(
        .SAMPLES_PER_SYMBOL(4),
        .ACC_W(42),
        .THRESH(42'sd200000)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en_s), .sym_start(ss),
        .rx_sample(rx), .sampled_sine(sn), .sampled_cosine(cs),
        .symbol(sym_s), .symbol_valid(val_s), .i_acc_out(i_s), .q_acc_out(q_s), .busy(busy_s)
    );

    qam_demod_correlator dut_l (
        .clk(clk), .rst(rst), .en(en_l), .sym_start(ss),
        .rx_sample(rx), .sampled_sine(sn), .sampled_cosine(cs),
        .symbol(sym_l), .symbol_valid(val_l), .i_acc_out(i_l), .q_acc_out(q_l), .busy(busy_l)
    );

    typedef struct {
        longint i;
        longint q;
        int     sym;
        int     cyc;
    } rec_t;

    rec_t rs[$];
    rec_t rl[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (val_s) rs.push_back('{longint'(i_s), longint'(q_s), int'(sym_s), cyc});
        if (val_l) rl.push_back('{longint'(i_l), longint'(q_l), int'(sym_l), cyc});
    end

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic smp(input bit big, input int r, input int c, input int s, input bit st);
        rx = 16'(r);
        cs = 16'(c);
        sn = 16'(s);
        ss = st;
        if (big) en_l = 1'b1;
        else     en_s = 1'b1;
        @(posedge clk);
        #1;
        last_edge = cyc;
        en_s = 1'b0;
        en_l = 1'b0;
        ss   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
    endtask

    task automatic sym_small(input int r, input int c, input int s, input bit st);
        for (int k = 0; k < 4; k++) smp(1'b0, r, c, s, st && (k == 0));
    endtask

    task automatic big_sym(input int r0, input int c0, input int r1, input int c1,
                           input bit fs, input bit st);
        for (int k = 0; k < 1024; k++) begin
            if (fs)          smp(1'b1, -32768, -32768, -32768, st && (k == 0));
            else if (k == 0) smp(1'b1, r0, c0, 0, st);
            else if (k == 1) smp(1'b1, r1, c1, 0, 1'b0);
            else             smp(1'b1, 0, 0, 0, 1'b0);
        end
    endtask

    task automatic fetch(input bit big, input int n, output rec_t r);
        int w = 0;
        while (((big ? rl.size() : rs.size()) <= n) && (w < 3000)) begin
            @(posedge clk);
            w++;
        end
        #1;
        if ((big ? rl.size() : rs.size()) <= n) begin
            chk("fetch_timeout", big ? rl.size() : rs.size(), n + 1);
            r = '{0, 0, -1, -1};
        end else begin
            r = big ? rl[n] : rs[n];
        end
    endtask

    longint exp_i[7] = '{64'sd1099511627776, 268435456, 268435455, 0, -1, -268435456, -268435457};
    int     exp_y[7] = '{4'b1010, 4'b1011, 4'b1111, 4'b1111, 4'b0111, 4'b0111, 4'b0011};

    initial begin
        rec_t r, r2;
        int   e1;
        rst = 1'b0; en_s = 1'b0; en_l = 1'b0; ss = 1'b0;
        rx = '0; sn = '0; cs = '0;
        idle(3);
        rst = 1'b1;

        chk("rst_symbol", sym_s, 0);
        chk("rst_valid", val_s, 0);
        chk("rst_i", i_s, 0);
        chk("rst_q", q_s, 0);
        chk("rst_busy_s", busy_s, 0);
        chk("rst_busy_l", busy_l, 0);

        // Test 1: plain symbol
        smp(1'b0, 100, 1000, 0, 1'b1);
        chk("t1_busy", busy_s, 1);
        for (int k = 1; k < 4; k++) smp(1'b0, 100, 1000, 0, 1'b0);
        e1 = last_edge;
        fetch(1'b0, 0, r);
        chk("t1_i", r.i, 400000);
        chk("t1_q", r.q, 0);
        chk("t1_sym", r.sym, 4'b1011);
        chk("t1_latency", r.cyc, e1 + 2);
        idle(3);
        chk("t1_pulses", rs.size(), 1);
        chk("t1_hold_i", i_s, 400000);
        chk("t1_valid_low", val_s, 0);

        // Test 2: back-to-back symbols
        do_reset();
        sym_small(-100, 1000, -500, 1'b1);
        e1 = last_edge;
        sym_small(50, 1000, 1000, 1'b0);
        fetch(1'b0, 1, r);
        fetch(1'b0, 2, r2);
        chk("t2a_i", r.i, -400000);
        chk("t2a_q", r.q, 200000);
        chk("t2a_sym", r.sym, 4'b0010);
        chk("t2a_latency", r.cyc, e1 + 2);
        chk("t2b_i", r2.i, 200000);
        chk("t2b_q", r2.q, 200000);
        chk("t2b_sym", r2.sym, 4'b1010);
        chk("t2_gap", r2.cyc - r.cyc, 4);

        // Test 3: en bubbles 1,0,0,1,0,1,1
        do_reset();
        smp(1'b0, 100, 1000, 0, 1'b1);
        idle(2);
        smp(1'b0, 100, 1000, 0, 1'b0);
        idle(1);
        smp(1'b0, 100, 1000, 0, 1'b0);
        smp(1'b0, 100, 1000, 0, 1'b0);
        e1 = last_edge;
        fetch(1'b0, 3, r);
        chk("t3_i", r.i, 400000);
        chk("t3_q", r.q, 0);
        chk("t3_sym", r.sym, 4'b1011);
        chk("t3_latency", r.cyc, e1 + 2);

        // Test 4: resync on sample 2
        do_reset();
        smp(1'b0, 1000, 1000, 1000, 1'b1);
        smp(1'b0, 1000, 1000, 1000, 1'b0);
        sym_small(-100, 1000, -500, 1'b1);
        e1 = last_edge;
        fetch(1'b0, 4, r);
        chk("t4_i", r.i, -400000);
        chk("t4_q", r.q, 200000);
        chk("t4_sym", r.sym, 4'b0010);
        chk("t4_latency", r.cyc, e1 + 2);
        idle(3);
        chk("t4_pulses", rs.size(), 5);

        // Test 5: reset during sample 3 (outputs currently hold test 4 result)
        for (int k = 0; k < 3; k++) smp(1'b0, 100, 1000, 0, k == 0);
        rx = 16'sd100; cs = 16'sd1000; sn = '0; en_s = 1'b1; rst = 1'b0;
        @(posedge clk);
        #1;
        en_s = 1'b0; rst = 1'b1;
        chk("t5_symbol", sym_s, 0);
        chk("t5_i", i_s, 0);
        chk("t5_q", q_s, 0);
        chk("t5_busy", busy_s, 0);
        chk("t5_valid", val_s, 0);
        sym_small(100, 1000, 0, 1'b0);
        idle(4);
        chk("t5_ignored_busy", busy_s, 0);
        chk("t5_no_pulse", rs.size(), 5);
        sym_small(-100, 1000, -500, 1'b1);
        fetch(1'b0, 5, r);
        chk("t5_resume_i", r.i, -400000);
        chk("t5_resume_sym", r.sym, 4'b0010);

        // Test 6: default parameters, full scale then threshold boundaries on I
        big_sym(0, 0, 0, 0, 1'b1, 1'b1);
        big_sym(16384, 16384, 0, 0, 1'b0, 1'b0);
        big_sym(16384, 16384, -1, 1, 1'b0, 1'b0);
        big_sym(0, 0, 0, 0, 1'b0, 1'b0);
        big_sym(-1, 1, 0, 0, 1'b0, 1'b0);
        big_sym(-16384, 16384, 0, 0, 1'b0, 1'b0);
        big_sym(-16384, 16384, -1, 1, 1'b0, 1'b0);
        for (int n = 0; n < 7; n++) begin
            fetch(1'b1, n, r);
            chk($sformatf("t6_i_%0d", n), r.i, exp_i[n]);
            chk($sformatf("t6_sym_%0d", n), r.sym, exp_y[n]);
        end
        fetch(1'b1, 0, r);
        chk("t6_fullscale_q", r.q, 64'sd1099511627776);
        idle(3);
        chk("t6_pulses", rl.size(), 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
